// File: rtl/ooo_pkg.sv
// Shared types and widths for the out-of-order core's writeback path.
package ooo_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: the search starts one past the last winner.
// Shared by writeback, issue-port and CDB arbitration.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] rr_ptr;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(rr_ptr) + k) % N]) begin
        grant                              = '0;
        grant[(int'(rr_ptr) + k) % N]      = 1'b1;
        grant_idx                          = IDX_W'((int'(rr_ptr) + k) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr <= IDX_W'(N - 1);
    end else if (advance) begin
      rr_ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among writeback sources and forwards
// the in-flight write to two read ports. Writes to x0 are acked for free.
module regfile_wb_arbiter
  import ooo_pkg::REG_ADDR_W;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = ooo_pkg::XLEN
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          reg_write,
  output logic [REG_ADDR_W-1:0]         rd,
  output logic [XLEN-1:0]               reg_write_data,
  input  logic [REG_ADDR_W-1:0]         fwd_rs1,
  input  logic [REG_ADDR_W-1:0]         fwd_rs2,
  output logic                          fwd_rs1_hit,
  output logic                          fwd_rs2_hit,
  output logic [XLEN-1:0]               fwd_rs1_data,
  output logic [XLEN-1:0]               fwd_rs2_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    live_req;
  logic [NUM_REQ-1:0]    null_req;
  logic [NUM_REQ-1:0]    live_grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  any_live;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  always_comb begin
    live_req = '0;
    null_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      live_req[i] = req_valid[i] && (req_rd[i*REG_ADDR_W +: REG_ADDR_W] != '0);
      null_req[i] = req_valid[i] && (req_rd[i*REG_ADDR_W +: REG_ADDR_W] == '0);
    end
  end

  assign any_live = |live_req;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (live_req),
    .advance   (any_live),
    .grant     (live_grant),
    .grant_idx (grant_idx)
  );

  // x0 writes never touch the port, so they are acked alongside the winner.
  assign req_ready = null_req | live_grant;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reg_write      <= 1'b0;
      rd             <= '0;
      reg_write_data <= '0;
    end else begin
      reg_write <= any_live;
      if (any_live) begin
        rd             <= sel_rd;
        reg_write_data <= sel_data;
      end
    end
  end

  // Covers the cycle before the register file holds the value.
  assign fwd_rs1_hit  = reg_write && (fwd_rs1 == rd) && (fwd_rs1 != '0);
  assign fwd_rs2_hit  = reg_write && (fwd_rs2 == rd) && (fwd_rs2 != '0);
  assign fwd_rs1_data = reg_write_data;
  assign fwd_rs2_data = reg_write_data;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port among `NUM_REQ` writeback sources (ALU, LSU, MUL/DIV, ...) in the out-of-order core. It uses round-robin arbitration with valid/ready handshakes and registers the winning write for one cycle onto `reg_write`/`rd`/`reg_write_data`. It also forwards that in-flight write to two read ports, covering the cycle before the register file holds the value. Writes to x0 are acknowledged without consuming the port.

## Interface
- `NUM_REQ`, 3, number of writeback requesters (2..8)
- `XLEN`, 32, data width
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  synchronous, active-low reset
- `req_valid`  in  NUM_REQ  requester i has a write pending
- `req_rd`  in  NUM_REQ x 5  destination register per requester
- `req_data`  in  NUM_REQ x XLEN  write data per requester
- `req_ready`  out  NUM_REQ  grant; a transfer occurs when valid && ready
- `reg_write`  out  1  write enable to register file (registered)
- `rd`  out  5  write address (registered)
- `reg_write_data`  out  XLEN  write data (registered)
- `fwd_rs1`, `fwd_rs2`  in  5  read addresses being issued to the register file
- `fwd_rs1_hit`, `fwd_rs2_hit`  out  1  in-flight write matches that address
- `fwd_rs1_data`, `fwd_rs2_data`  out  XLEN  in-flight write data (valid when hit)

## Operation
- Requests are split into two classes. A request is **live** when `req_valid[i] && req_rd[i] != 0`. A request is **null** when `req_valid[i] && req_rd[i] == 0`.
- Null requests get `req_ready[i]=1` combinationally in the same cycle, for all such i in parallel. They do not use the port, move `rr_ptr`, or drive `reg_write`.
- Live requests go through round-robin arbitration. The search starts at `(rr_ptr+1) mod NUM_REQ` and the first live request found is granted. Exactly one live request is granted per cycle whenever any live request exists.
- On a live grant to index g:
  - Next cycle: `reg_write=1`, `rd=req_rd[g]`, `reg_write_data=req_data[g]`.
  - `rr_ptr` takes the value g.
- With no live grant, the next cycle has `reg_write=0`. `rd` and `reg_write_data` hold their last values and are don't-care.
- `req_ready` is a function of `req_valid`, `req_rd` and `rr_ptr` only. It never depends on its own outputs, so there is no combinational loop.
- A requester may drop `req_valid` without a grant. The arbiter keeps no per-request state.
- Forwarding compares each read address against the in-flight write. `fwd_rsN_hit = reg_write && (fwd_rsN == rd) && (fwd_rsN != 0)`, and `fwd_rsN_data = reg_write_data`. This path is purely combinational from the registered state.
- Fairness: a continuously live requester is granted within `NUM_REQ` cycles of asserting valid.
- Reset (`reset_n=0` sampled at a rising edge) produces:
  - `reg_write=0`, `rd=0`, `reg_write_data=0`
  - `rr_ptr=NUM_REQ-1`, so index 0 has first priority
  - all `fwd_*_hit=0`
  - `req_ready` still reflects the null-request rule and the arbitration of the current inputs. Requesters must hold valid low during reset.
- Reset asserted in the same cycle as a grant cancels that write. `reg_write` is 0 in the following cycle.

## Timing
- Grant at cycle t → `reg_write` high during t+1 → register file updated at the end of t+1 → readable from the register file at t+2.
- The t+1 gap is covered by the forwarding outputs.
- The sustained throughput is one live write per cycle.
- Latency from request to port is one cycle for an uncontended request. Worst case under contention is `NUM_REQ` cycles.
- Two requesters targeting the same `rd` in one cycle: only one is granted. The other is written on a later cycle, so the later grant wins. Ordering between requesters is the issuer's responsibility.

## Structure
- The shared package `ooo_pkg` holds `XLEN`, `REG_ADDR_W=5`, and `typedef struct packed {logic [REG_ADDR_W-1:0] rd; logic [XLEN-1:0] data;} wb_req_t`.
- The natural sub-module is `rr_arbiter`, parameterised by `N`:
  - inputs: `req[N-1:0]`, `advance`
  - outputs: `grant` (one-hot), `grant_idx`
  - owns the `rr_ptr` register and its synchronous active-low reset
  - reused later for issue-port and CDB arbitration
- The top level contains the null/live split, the output register and the forwarding comparators.

## Test plan
- **Reset:** hold `reset_n=0` for 2 cycles with all valids high → `reg_write=0`, `rd=0`, no forwarding hits. The first live grant after reset goes to index 0.
- **Single requester:** requester 1 writes rd=5, data=0xDEADBEEF at t → `req_ready[1]=1` at t; `reg_write=1`, `rd=5`, `reg_write_data=0xDEADBEEF` at t+1; `fwd_rs1=5` gives hit with 0xDEADBEEF at t+1 and no hit at t+2.
- **Contention:** all 3 requesters held valid with rd=1/2/3 → grants in order 0,1,2,0,1,2. Each requester is granted exactly once per 3 cycles and `reg_write` is high every cycle.
- **x0 writes:** requester 0 has rd=0 and requester 2 has rd=7, both valid → both ready in the same cycle. The next cycle has `reg_write=1`, `rd=7`, and `rr_ptr` is 2. A request set of only rd=0 writes gives `reg_write=0` next cycle.
- **Forward x0 guard:** `fwd_rs2=0` while `reg_write=1` with `rd=0` is not reachable. With `fwd_rs2=0` and any in-flight write → `fwd_rs2_hit=0` always.
- **Reset mid-operation:** a grant at t with `reset_n=0` at t → `reg_write=0` at t+1 and the arbiter restarts with priority at index 0.
